// File: rtl/lisa_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// An owner holds the transmitter until its last byte drains or its lock times out.

module lisa_uart_tx_arb_lane (
  input  logic       own,
  input  logic       rdy_en,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       acc,
  output logic [7:0] data_o
);
  assign req_ready = own & rdy_en;
  assign acc       = req_ready & req_valid;
  // Masked so the top can OR all lanes into tx_d; tx_d is zero unless a write happens.
  assign data_o    = acc ? req_data : 8'h00;
endmodule

module lisa_uart_tx_arb #(
  parameter int NREQ         = 3,
  parameter int LOCK_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic [7:0]           tx_d,
  output logic                 tx_wr,
  input  logic                 tx_buf_empty,
  output logic                 busy,
  output logic                 timeout_evt
);
  localparam int              PW       = $clog2(NREQ);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(LOCK_TIMEOUT);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ-1);

  typedef enum logic [2:0] {IDLE, READY, HOLDOFF1, HOLDOFF2, WAIT_EMPTY} state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                last_q, last_d;
  logic                tev_q, tev_d;

  logic                rdy_en;
  logic [NREQ-1:0]     lane_acc;
  logic [NREQ-1:0][7:0] lane_data;
  logic                own_valid, own_last;
  logic [PW-1:0]       next_ptr;
  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic [TO_W-1:0]     to_inc;

  assign rdy_en = (state_q == READY) & tx_buf_empty;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    lisa_uart_tx_arb_lane u_lane (
      .own       (grant_q[i]),
      .rdy_en    (rdy_en),
      .req_valid (req_valid[i]),
      .req_data  (req_data[8*i +: 8]),
      .req_ready (req_ready[i]),
      .acc       (lane_acc[i]),
      .data_o    (lane_data[i])
    );
  end

  always_comb begin
    tx_d = '0;
    for (int i = 0; i < NREQ; i++) tx_d = tx_d | lane_data[i];
  end

  assign tx_wr       = |lane_acc;
  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign timeout_evt = tev_q;
  assign own_valid   = req_valid[owner_q];
  assign own_last    = req_last[owner_q];
  assign next_ptr    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign to_inc      = to_cnt_q + 1'b1;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    to_cnt_d = to_cnt_q;
    last_d   = last_q;
    tev_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d  = NREQ'(1) << pick_idx;
          owner_d  = pick_idx;
          to_cnt_d = '0;
          state_d  = READY;
        end
      end
      READY: begin
        if (tx_wr) begin
          last_d   = own_last;
          to_cnt_d = '0;
          state_d  = HOLDOFF1;
        end else if (!own_valid) begin
          // Only an absent owner burns lock time; a stalled UART does not.
          to_cnt_d = to_inc;
          if (LOCK_TIMEOUT != 0 && to_inc == TO_LIM) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            to_cnt_d = '0;
            tev_d    = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      HOLDOFF1: state_d = HOLDOFF2;
      HOLDOFF2: state_d = WAIT_EMPTY;
      WAIT_EMPTY: begin
        if (tx_buf_empty) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            to_cnt_d = '0;
            state_d  = READY;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      to_cnt_q <= '0;
      last_q   <= 1'b0;
      tev_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      last_q   <= last_d;
      tev_q    <= tev_d;
    end
  end
endmodule

// File: tb/tb_lisa_uart_tx_arb.sv
// Bench for lisa_uart_tx_arb: queued requesters, a UART busy-time model and a
// packet-level round-robin reference predicting the transmitted byte stream.
module tb_lisa_uart_tx_arb;
  localparam int NREQ = 3, LOCK_TIMEOUT = 255, TO_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     req_last = '0;
  logic [NREQ-1:0]     req_ready, grant;
  logic [7:0]          tx_d;
  logic                tx_wr, busy, timeout_evt;
  logic                tx_buf_empty = 1'b1;

  always #5 clk = ~clk;

  lisa_uart_tx_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(LOCK_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_d(tx_d), .tx_wr(tx_wr),
    .tx_buf_empty(tx_buf_empty), .busy(busy), .timeout_evt(timeout_evt));

  int n_checks = 0, n_fail = 0;
  logic [7:0] rq_data [NREQ][64];
  bit         rq_last [NREQ][64];
  int         rq_head [NREQ];
  int         rq_tail [NREQ];
  int uart_gap = 0, uart_cnt = 0, cyc = 0, model_rr = 0;
  bit force_low = 0;
  logic [NREQ-1:0] s_grant, s_ready;
  logic [7:0] s_txd;
  logic s_txwr, s_busy, s_tev;

  task automatic load_pkt(input int r, input int len, input logic [7:0] base, input bit with_last);
    for (int b = 0; b < len; b++) begin
      rq_data[r][rq_tail[r]] = base + 8'(b);
      rq_last[r][rq_tail[r]] = with_last && (b == len - 1);
      rq_tail[r]++;
    end
  endtask

  function automatic bit drained();
    for (int r = 0; r < NREQ; r++) if (rq_head[r] != rq_tail[r]) return 1'b0;
    return 1'b1;
  endfunction

  // One cycle: drive at negedge, sample settled outputs, then update requesters and UART.
  task automatic step();
    @(negedge clk);
    tx_buf_empty = force_low ? 1'b0 : (uart_cnt == 0);
    for (int r = 0; r < NREQ; r++) begin
      if (rq_head[r] < rq_tail[r]) begin
        req_valid[r] = 1'b1;
        req_data[8*r +: 8] = rq_data[r][rq_head[r]];
        req_last[r] = rq_last[r][rq_head[r]];
      end else begin
        req_valid[r] = 1'b0;
        req_data[8*r +: 8] = 8'h00;
        req_last[r] = 1'b0;
      end
    end
    #1;
    s_grant = grant; s_ready = req_ready; s_txd = tx_d;
    s_txwr = tx_wr; s_busy = busy; s_tev = timeout_evt;
    for (int r = 0; r < NREQ; r++) if (req_valid[r] && s_ready[r]) rq_head[r]++;
    if (s_txwr) uart_cnt = uart_gap;
    else if (uart_cnt > 0) uart_cnt--;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int r = 0; r < NREQ; r++) begin rq_head[r] = 0; rq_tail[r] = 0; end
    uart_cnt = 0; force_low = 0; tx_buf_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
  endtask

  task automatic drain_release(input string name);
    bit rel = 0;
    for (int c = 0; c < 40 && !rel; c++) begin
      step();
      if (s_grant == '0) rel = 1;
    end
    n_checks++;
    if (!rel) begin n_fail++; $display("FAIL %s_release: grant=%b, want 000", name, s_grant); end
  endtask

  // Reference: whole packets in round-robin order from model_rr, pointer = owner+1 after each.
  task automatic run_model(input string name, input int budget);
    logic [7:0] exp_b[$];
    int exp_o[$];
    int h[NREQ];
    int rr, own, n_wr, last_cyc, bad;
    bit found, done;
    for (int r = 0; r < NREQ; r++) h[r] = rq_head[r];
    rr = model_rr; own = 0;
    while (1) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (rr + k) % NREQ;
        if (!found && h[r] < rq_tail[r]) begin found = 1; own = r; end
      end
      if (!found) break;
      do begin
        exp_b.push_back(rq_data[own][h[own]]);
        exp_o.push_back(own);
        h[own]++;
      end while (!rq_last[own][h[own]-1]);
      rr = (own + 1) % NREQ;
    end
    n_wr = 0; last_cyc = -100; bad = 0; done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      if ((s_ready & ~s_grant) != '0) bad++;
      if (s_busy !== (s_grant != '0)) bad++;
      if (!$onehot0(s_grant)) bad++;
      if (s_tev) bad++;
      if (s_txwr && !tx_buf_empty) bad++;
      if (!s_txwr && s_txd != 8'h00) bad++;
      if (s_txwr) begin
        if (n_wr < exp_b.size()) begin
          n_checks++;
          if (s_txd !== exp_b[n_wr] || s_grant !== (NREQ'(1) << exp_o[n_wr])) begin
            n_fail++;
            $display("FAIL %s_byte%0d: tx_d=%h grant=%b, want tx_d=%h grant=%b",
                     name, n_wr, s_txd, s_grant, exp_b[n_wr], NREQ'(1) << exp_o[n_wr]);
          end
        end
        if (cyc - last_cyc < 4) bad++;
        last_cyc = cyc;
        n_wr++;
      end
      if (drained() && s_grant == '0 && !s_txwr) done = 1;
    end
    n_checks++;
    if (n_wr != exp_b.size()) begin n_fail++; $display("FAIL %s_count: writes=%0d, want %0d", name, n_wr, exp_b.size()); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_protocol: violations=%0d, want 0", name, bad); end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL %s_finish: not drained/released in %0d cycles", name, budget); end
    model_rr = rr;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (grant !== '0)       begin n_fail++; $display("FAIL rst_grant: %b, want 000", grant); end
    n_checks++; if (req_ready !== '0)   begin n_fail++; $display("FAIL rst_ready: %b, want 000", req_ready); end
    n_checks++; if (tx_wr !== 1'b0)     begin n_fail++; $display("FAIL rst_txwr: %b, want 0", tx_wr); end
    n_checks++; if (tx_d !== 8'h00)     begin n_fail++; $display("FAIL rst_txd: %h, want 00", tx_d); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: %b, want 0", busy); end
    n_checks++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL rst_tev: %b, want 0", timeout_evt); end
  endtask

  task automatic test_single();
    int extra = 0;
    bit rel = 0;
    do_reset();
    uart_gap = 3;
    load_pkt(1, 1, 8'h41, 1);
    step();
    n_checks++; if (s_grant !== 3'b000) begin n_fail++; $display("FAIL single_idle: grant=%b, want 000", s_grant); end
    step();
    n_checks++;
    if (s_grant !== 3'b010 || s_txwr !== 1'b1 || s_txd !== 8'h41) begin
      n_fail++; $display("FAIL single_write: grant=%b tx_wr=%b tx_d=%h, want 010/1/41", s_grant, s_txwr, s_txd);
    end
    for (int c = 0; c < 20 && !rel; c++) begin
      step();
      if (s_txwr) extra++;
      if (s_grant == '0) rel = 1;
    end
    n_checks++;
    if (!rel || extra != 0) begin n_fail++; $display("FAIL single_release: released=%0d extra_writes=%0d, want 1/0", rel, extra); end
    model_rr = 2;
    // Pointer should now sit at requester 2, so it beats requester 0.
    load_pkt(0, 1, 8'h50, 1);
    load_pkt(2, 1, 8'h52, 1);
    run_model("single_rr", 200);
  endtask

  task automatic test_two_packets();
    do_reset();
    uart_gap = 20;
    load_pkt(0, 3, 8'h10, 1);
    load_pkt(2, 3, 8'h20, 1);
    run_model("two_pkts", 600);
  endtask

  task automatic test_timeout();
    int n0 = 0, t_acc = -1, t_evt = -1, leak = 0;
    logic [NREQ-1:0] g_at = '1;
    do_reset();
    uart_gap = 0;
    load_pkt(0, 2, 8'hA0, 0);
    load_pkt(1, 1, 8'hB0, 1);
    for (int c = 0; c < 600 && t_evt < 0; c++) begin
      step();
      if (s_txwr && s_grant == 3'b001) begin n0++; if (n0 == 2) t_acc = cyc; end
      if (s_ready[1] || (s_txwr && s_grant != 3'b001)) leak++;
      if (s_tev) begin t_evt = cyc; g_at = s_grant; end
    end
    // After the accept: HOLDOFF1, HOLDOFF2, one WAIT_EMPTY, LOCK_TIMEOUT idle READY cycles, then the registered release.
    n_checks++;
    if (t_acc < 0 || t_evt < 0 || t_evt - t_acc != 3 + LOCK_TIMEOUT + 1) begin
      n_fail++; $display("FAIL to_latency: delta=%0d (acc=%0d evt=%0d), want %0d", t_evt - t_acc, t_acc, t_evt, 3 + LOCK_TIMEOUT + 1);
    end
    n_checks++; if (g_at !== 3'b000) begin n_fail++; $display("FAIL to_grant_clear: grant=%b, want 000", g_at); end
    n_checks++; if (leak != 0) begin n_fail++; $display("FAIL to_integrity: leaks=%0d, want 0", leak); end
    step();
    n_checks++;
    if (s_grant !== 3'b010 || s_txwr !== 1'b1 || s_txd !== 8'hB0 || s_tev !== 1'b0) begin
      n_fail++; $display("FAIL to_next_owner: grant=%b tx_wr=%b tx_d=%h tev=%b, want 010/1/b0/0", s_grant, s_txwr, s_txd, s_tev);
    end
    drain_release("to");
  endtask

  task automatic test_rr_all();
    do_reset();
    uart_gap = 0;
    for (int r = 0; r < NREQ; r++) begin
      load_pkt(r, 1, 8'(8'h30 + 16 * r), 1);
      load_pkt(r, 1, 8'(8'h31 + 16 * r), 1);
    end
    run_model("rr_all", 200);
  endtask

  task automatic test_buf_stall();
    int bad = 0;
    do_reset();
    uart_gap = 0;
    force_low = 1;
    load_pkt(2, 1, 8'h7E, 1);
    repeat (300) begin
      step();
      if (s_ready != '0 || s_txwr || s_tev) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_quiet: violations=%0d, want 0", bad); end
    n_checks++; if (s_grant !== 3'b100) begin n_fail++; $display("FAIL stall_grant: grant=%b, want 100", s_grant); end
    force_low = 0;
    step();
    n_checks++;
    if (s_txwr !== 1'b1 || s_txd !== 8'h7E || s_ready !== 3'b100) begin
      n_fail++; $display("FAIL stall_resume: tx_wr=%b tx_d=%h ready=%b, want 1/7e/100", s_txwr, s_txd, s_ready);
    end
    drain_release("stall");
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    uart_gap = 2;
    load_pkt(0, 3, 8'hC0, 1);
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (s_txwr) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_first_write: no tx_wr within 10 cycles, want one"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== '0 || tx_wr !== 1'b0 || req_ready !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs: grant=%b tx_wr=%b ready=%b busy=%b, want 0", grant, tx_wr, req_ready, busy);
    end
    for (int r = 0; r < NREQ; r++) begin rq_head[r] = 0; rq_tail[r] = 0; end
    req_valid = '0; req_data = '0; req_last = '0; uart_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    // Pointer back at 0: requester 0 must win over requester 2.
    load_pkt(0, 1, 8'hD0, 1);
    load_pkt(2, 1, 8'hD2, 1);
    run_model("mid_rst", 200);
  endtask

  task automatic test_random();
    do_reset();
    for (int round = 0; round < 4; round++) begin
      uart_gap = $urandom_range(0, 6);
      for (int r = 0; r < NREQ; r++) begin
        int np;
        rq_head[r] = 0; rq_tail[r] = 0;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) load_pkt(r, $urandom_range(1, 3), 8'($urandom), 1);
      end
      run_model("random", 3000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_packets();
    test_timeout();
    test_rr_all();
    test_buf_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
